uart_tx: RTL

Byte-wide UART transmitter: 8N1 serial framing on `TX`, LSB first, at a fixed bit period of `BAUD_DIV` clocks (100 MHz / 108 ≈ 921600 baud by default). It sits between the command/response logic and the serial pin. The matching UART receiver uses the same framing and bit period. A one-deep holding register lets the host queue the next byte while the current frame shifts out, so frames go back-to-back with no idle gap.

---
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_tx.sv | 74 +++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: host-side write handshake and serial line of uart_tx
interface uart_tx_if;
  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_rdy;
  logic       busy;
  logic       tx_done;
  logic       TX;
  modport master (output trmt, tx_data, input tx_rdy, busy, tx_done, TX);
  modport slave (input trmt, tx_data, output tx_rdy, busy, tx_done, TX);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with one-deep holding register; define UART_TX_PARITY_EN for an even parity bit
module uart_tx #(
  parameter int BAUD_DIV = 108
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus
);
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int BW = $clog2(BAUD_DIV);
  typedef enum logic {IDLE, TXING} state_t;
  state_t           state;
  logic [7:0]       hold;
  logic             hold_full;
  logic [FRAME-1:0] shft;
  logic [FRAME-1:0] frame;
  logic [BW-1:0]    baud_cnt;
  logic [3:0]       bit_cnt;
  logic             done;
  logic             shift;
  logic             frame_end;
  logic             wr;
  logic             load;
`ifdef UART_TX_PARITY_EN
  assign frame = {1'b1, ^hold, hold, 1'b0};
`else
  assign frame = {1'b1, hold, 1'b0};
`endif
  assign shift     = state == TXING && baud_cnt == BW'(BAUD_DIV - 1);
  assign frame_end = shift && bit_cnt == 4'(FRAME - 1);
  assign wr        = bus.trmt && !hold_full;
  // a queued byte loads on the very edge the previous stop bit ends, so no idle bit
  assign load      = hold_full && (state == IDLE || frame_end);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shft      <= '1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      done      <= 1'b0;
    end else begin
      done <= frame_end;
      if (wr) begin
        hold      <= bus.tx_data;
        hold_full <= 1'b1;
      end
      if (load) begin
        shft      <= frame;
        hold_full <= 1'b0;
        baud_cnt  <= '0;
        bit_cnt   <= '0;
        state     <= TXING;
      end else if (frame_end) begin
        shft  <= '1;
        state <= IDLE;
      end else if (state == TXING) begin
        baud_cnt <= shift ? '0 : baud_cnt + 1'b1;
        if (shift) begin
          shft    <= {1'b1, shft[FRAME-1:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  assign bus.TX      = shft[0];
  assign bus.tx_done = done;
  assign bus.tx_rdy  = !hold_full;
  assign bus.busy    = state == TXING || hold_full;
endmodule
